led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Sequencer for the board's LED string: owns a single shared half-period timer and steps an NUM_LEDS-wide pattern through one of four modes (off, blink-all, chase, bounce), replacing per-LED free-running blinkers. Sits between the top-level configuration source and the LED pins; accepts mode and half-period over a valid/ready handshake and can be paused without losing pattern state.

## Interface
- NUM_LEDS, 8, number of LED outputs (≥1)
- CNT_W, 32, width of half-period and tick counter
- DEFAULT_HALF, 5, half-period (cycles) loaded at reset
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_mode  in  2  0 OFF, 1 BLINK_ALL, 2 CHASE, 3 BOUNCE
- cfg_half  in  CNT_W  cycles per pattern step (unsigned)
- enable  in  1  1 = run, 0 = freeze
- led  out  NUM_LEDS  LED drive, registered
- step_pulse  out  1  one-cycle strobe coincident with each pattern update

## Operation
- Reset values: led=0, step_pulse=0, cfg_ready=1, state IDLE, mode OFF, half=DEFAULT_HALF, tick=0, dir=up.
- Config accepted on any edge with cfg_valid & cfg_ready: latch mode, half; go LOAD. Accept is legal in IDLE, RUN, PAUSE (restarts pattern).
- half_eff = max(cfg_half, 1); cfg_half=0 behaves as 1.
- States: IDLE (led=0, waiting) -> LOAD (one cycle, cfg_ready=0, cfg_valid ignored) -> RUN or IDLE; RUN <-> PAUSE on enable.
- LOAD: tick<=0, dir<=up; led <= all ones (BLINK_ALL), bit0 only (CHASE, BOUNCE), 0 (OFF). Next state: IDLE if OFF, else RUN if enable, else PAUSE.
- RUN: tick increments each cycle; when tick==half_eff-1: tick<=0, pattern steps, step_pulse<=1. enable=0 -> PAUSE.
- PAUSE: tick, led, dir held; step_pulse=0; enable=1 -> RUN, counting resumes from held tick.
- BLINK_ALL step: led <= ~led.
- CHASE step: rotate left by one; MSB wraps to bit0.
- BOUNCE step: shift toward MSB while dir=up; on reaching bit NUM_LEDS-1 next step reverses (dir<=down), toward bit0 likewise. Sequence for 4 LEDs: 0001,0010,0100,1000,0100,0010,0001,0010...; NUM_LEDS=1: led stays 1.
- Tick compare is unsigned CNT_W; tick never exceeds half_eff-1.
- Config accepted in same cycle as a step: config wins; step discarded, no step_pulse.
- rst asserted mid-operation: all registers return to reset values immediately, independent of clk.

## Timing
- Accept at edge k -> LOAD during cycle k..k+1 -> initial pattern visible after edge k+1.
- First step: half_eff RUN cycles after LOAD; subsequent steps every half_eff RUN cycles. BLINK_ALL full period = 2*half_eff cycles (10 at default).
- led and step_pulse change on the same edge; step_pulse high exactly one cycle.
- cfg_ready low only during LOAD (one cycle); combinational from state.
- Pause latency: enable sampled each edge; enable=0 at edge blocks the step that edge would have made.

## Structure
- Shared package led_seq_pkg: mode encoding (OFF/BLINK_ALL/CHASE/BOUNCE), state encoding (IDLE/LOAD/RUN/PAUSE), DEFAULT_HALF.
- Sub-module led_tick_timer: CNT_W counter with clear, run, half_eff compare, step output; reusable by other LED blocks.
- Pattern register, dir and FSM stay in the top.

## Test plan
- Reset release, no config -> led=0, cfg_ready=1, step_pulse never asserts for 100 cycles.
- Config BLINK_ALL, half=5, enable=1 -> led=FF after accept+1, toggles every 5 cycles, step_pulse each toggle, period 10.
- Config CHASE, half=2, NUM_LEDS=8 -> 01,02,04,...,80,01 every 2 cycles; wrap verified.
- Config BOUNCE, half=1, NUM_LEDS=4 -> 1,2,4,8,4,2,1,2 on consecutive cycles.
- RUN with half=5, drop enable at tick=3 for 7 cycles -> led frozen, step occurs 2 cycles after enable returns; cfg_half=0 -> steps every cycle.
- Reassert rst mid-CHASE, and separately issue config in a step cycle -> led=0 asynchronously; config restart with no step_pulse.

Source files
------------

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_seq_pkg : shared encodings and reset defaults for the LED sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_BLINK_ALL = 2'd1,
    MODE_CHASE     = 2'd2,
    MODE_BOUNCE    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int LED_DEFAULT_HALF = 5;

endpackage
`default_nettype wire

// File: rtl/led_tick_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_tick_timer : half-period tick counter, strobes step on the last tick
// Revision       : 1.0
// ---------------------------------------------------------------------------
module led_tick_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             step
);

  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] half_eff;

  // A half-period of zero is treated as one so the counter always wraps.
  always_comb begin
    half_eff = (half == '0) ? CNT_W'(1) : half;
    step     = run && (tick == half_eff - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick <= '0;
    end else if (clear) begin
      tick <= '0;
    end else if (run) begin
      tick <= step ? '0 : tick + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pattern_sequencer : steps an LED pattern (off/blink/chase/bounce)
// Revision              : 1.0
// ---------------------------------------------------------------------------
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = LED_DEFAULT_HALF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse
);

  state_t              state, state_nxt;
  mode_t               mode;
  logic [CNT_W-1:0]    half;
  logic                dir_up, dir_nxt;
  logic [NUM_LEDS-1:0] led_nxt, led_init;
  logic                accept, active, tmr_clear, tmr_run, tmr_step;

  always_comb begin
    cfg_ready = (state != ST_LOAD);
    accept    = cfg_valid && cfg_ready;
    // Counting follows the sampled enable, so a paused pattern resumes on
    // the very edge enable returns.
    active    = enable && ((state == ST_RUN) || (state == ST_PAUSE));
    tmr_clear = accept || (state == ST_LOAD);
    tmr_run   = active && !accept;
  end

  led_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .run   (tmr_run),
    .half  (half),
    .step  (tmr_step)
  );

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:  state_nxt = (mode == MODE_OFF) ? ST_IDLE : (enable ? ST_RUN : ST_PAUSE);
        ST_RUN:   if (!enable) state_nxt = ST_PAUSE;
        ST_PAUSE: if (enable) state_nxt = ST_RUN;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    led_init = '0;
    led_nxt  = led;
    dir_nxt  = dir_up;
    case (mode)
      MODE_BLINK_ALL: led_init = '1;
      MODE_CHASE,
      MODE_BOUNCE:    led_init = NUM_LEDS'(1);
      default:        led_init = '0;
    endcase
    case (mode)
      MODE_BLINK_ALL: led_nxt = ~led;
      MODE_CHASE:     led_nxt = (led << 1) | (led >> (NUM_LEDS - 1));
      MODE_BOUNCE: begin
        // A single LED has nowhere to bounce; it simply stays lit.
        if (NUM_LEDS > 1) begin
          if (dir_up) begin
            if (led[NUM_LEDS-1]) begin
              led_nxt = led >> 1;
              dir_nxt = 1'b0;
            end else begin
              led_nxt = led << 1;
            end
          end else begin
            if (led[0]) begin
              led_nxt = led << 1;
              dir_nxt = 1'b1;
            end else begin
              led_nxt = led >> 1;
            end
          end
        end
      end
      default:        led_nxt = led;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mode       <= MODE_OFF;
      half       <= CNT_W'(DEFAULT_HALF);
      led        <= '0;
      dir_up     <= 1'b1;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_pulse <= 1'b0;
      if (accept) begin
        mode <= mode_t'(cfg_mode);
        half <= cfg_half;
      end else if (state == ST_LOAD) begin
        led    <= led_init;
        dir_up <= 1'b1;
      end else if (tmr_step) begin
        led        <= led_nxt;
        dir_up     <= dir_nxt;
        step_pulse <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_pattern_sequencer : directed self-checking bench for the sequencer
// Revision                 : 1.0
// ---------------------------------------------------------------------------
module tb_led_pattern_sequencer;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        enable    = 1'b0;
  logic [1:0]  cfg_mode  = 2'd0;
  logic [31:0] cfg_half  = 32'd0;
  logic        cfg_ready;
  logic        step_pulse;
  logic [7:0]  led;

  int checks = 0;
  int passed = 0;

  led_pattern_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_half   (cfg_half),
    .enable     (enable),
    .led        (led),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic do_cfg(input logic [1:0] m, input logic [31:0] h, input logic [7:0] init,
                        input string tag);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_half  = h;
    tick();
    cfg_valid = 1'b0;
    chk({tag, "_ready_in_load"}, 32'(cfg_ready), 32'd0);
    tick();
    chk({tag, "_init"}, 32'({step_pulse, led}), 32'({1'b0, init}));
    chk({tag, "_ready_after"}, 32'(cfg_ready), 32'd1);
  endtask

  task automatic run_step(input logic [7:0] prev, input logic [7:0] nxt, input int half,
                          input string tag);
    for (int i = 1; i < half; i++) begin
      tick();
      chk({tag, "_hold"}, 32'({step_pulse, led}), 32'({1'b0, prev}));
    end
    tick();
    chk({tag, "_step"}, 32'({step_pulse, led}), 32'({1'b1, nxt}));
  endtask

  logic [7:0] chase_seq  [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int         pulses;
    int         led_bad;
    logic [7:0] prev;

    // Reset held, then released with no configuration offered
    repeat (2) tick();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    rst     = 1'b1;
    pulses  = 0;
    led_bad = 0;
    repeat (100) begin
      tick();
      if (step_pulse) pulses++;
      if (led != 8'h00) led_bad++;
    end
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_led_nonzero", 32'(led_bad), 32'd0);
    chk("idle_ready", 32'(cfg_ready), 32'd1);

    // BLINK_ALL, half 5: full period 10
    enable = 1'b1;
    do_cfg(2'd1, 32'd5, 8'hFF, "blink");
    run_step(8'hFF, 8'h00, 5, "blink_a");
    run_step(8'h00, 8'hFF, 5, "blink_b");
    tick();
    chk("blink_pulse_one_cycle", 32'({step_pulse, led}), 32'({1'b0, 8'hFF}));

    // CHASE, half 2, including wrap from bit 7 to bit 0
    do_cfg(2'd2, 32'd2, 8'h01, "chase");
    prev = 8'h01;
    for (int i = 0; i < 8; i++) begin
      run_step(prev, chase_seq[i], 2, "chase");
      prev = chase_seq[i];
    end

    // BOUNCE, half 1: a step on every cycle
    do_cfg(2'd3, 32'd1, 8'h01, "bounce");
    prev = 8'h01;
    for (int i = 0; i < 15; i++) begin
      run_step(prev, bounce_seq[i], 1, "bounce");
      prev = bounce_seq[i];
    end

    // Pause at tick 3 for 7 cycles, step lands 2 cycles after resume
    do_cfg(2'd2, 32'd5, 8'h01, "pause");
    repeat (3) begin
      tick();
      chk("pause_pre", 32'({step_pulse, led}), 32'({1'b0, 8'h01}));
    end
    enable = 1'b0;
    repeat (7) begin
      tick();
      chk("pause_frozen", 32'({step_pulse, led}), 32'({1'b0, 8'h01}));
    end
    enable = 1'b1;
    tick();
    chk("pause_resume1", 32'({step_pulse, led}), 32'({1'b0, 8'h01}));
    tick();
    chk("pause_resume2", 32'({step_pulse, led}), 32'({1'b1, 8'h02}));

    // Half of zero behaves as one
    do_cfg(2'd2, 32'd0, 8'h01, "half0");
    run_step(8'h01, 8'h02, 1, "half0_a");
    run_step(8'h02, 8'h04, 1, "half0_b");

    // Configuration offered on a step edge wins over the step
    do_cfg(2'd2, 32'd2, 8'h01, "cfgwin");
    tick();
    chk("cfgwin_pre", 32'({step_pulse, led}), 32'({1'b0, 8'h01}));
    cfg_valid = 1'b1;
    cfg_mode  = 2'd1;
    cfg_half  = 32'd3;
    tick();
    cfg_valid = 1'b0;
    chk("cfgwin_no_step", 32'({step_pulse, led}), 32'({1'b0, 8'h01}));
    chk("cfgwin_ready_low", 32'(cfg_ready), 32'd0);
    tick();
    chk("cfgwin_load", 32'({step_pulse, led}), 32'({1'b0, 8'hFF}));
    run_step(8'hFF, 8'h00, 3, "cfgwin_blink");

    // Asynchronous reset in the middle of a chase
    do_cfg(2'd2, 32'd2, 8'h01, "arst");
    run_step(8'h01, 8'h02, 2, "arst_a");
    run_step(8'h02, 8'h04, 2, "arst_b");
    #2;
    rst = 1'b0;
    #1;
    chk("arst_async_led", 32'({step_pulse, led}), 32'd0);
    chk("arst_async_ready", 32'(cfg_ready), 32'd1);
    tick();
    rst = 1'b1;
    repeat (4) begin
      tick();
      chk("arst_idle_after", 32'({step_pulse, led}), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
